// File: rtl/stack_pointer_unit.sv
// Main-stack and return-stack pointer registers for the stack CPU.
// Executes push/pop/clear commands, derives memory addresses and sets sticky overflow/underflow flags.
module stack_pointer_unit #(
    parameter logic [15:0] MSP_BASE   = 16'h0E00,
    parameter logic [15:0] RSP_BASE   = 16'h0F00,
    parameter int unsigned DEPTH_LOG2 = 8
) (
    input  logic                  CLK,
    input  logic                  RstN,
    input  logic                  MSPWrite,
    input  logic                  MSPop,
    input  logic                  MSPRegReset,
    input  logic                  RSPWrite,
    input  logic                  RSPop,
    input  logic                  RSPRegReset,
    output logic [15:0]           MSPPushAddr,
    output logic [15:0]           MSPTopAddr,
    output logic [DEPTH_LOG2:0]   MSPCount,
    output logic                  MSPEmpty,
    output logic                  MSPFull,
    output logic                  MSPOverflow,
    output logic                  MSPUnderflow,
    output logic [15:0]           RSPPushAddr,
    output logic [15:0]           RSPTopAddr,
    output logic [DEPTH_LOG2:0]   RSPCount,
    output logic                  RSPEmpty,
    output logic                  RSPFull,
    output logic                  RSPOverflow,
    output logic                  RSPUnderflow,
    output logic                  StackFault
);

    // Commands are single-cycle strobes with no back-pressure: a Write (or
    // RegReset) sampled high at a rising edge is always consumed by that edge.
    localparam logic [DEPTH_LOG2:0] CNT_CAP  = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] CNT_ZERO = '0;
    localparam logic [DEPTH_LOG2:0] CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};

    logic [DEPTH_LOG2:0] msp_cnt;
    logic                msp_ovf;
    logic                msp_udf;
    logic [DEPTH_LOG2:0] rsp_cnt;
    logic                rsp_ovf;
    logic                rsp_udf;

    logic msp_full;
    logic msp_empty;
    logic rsp_full;
    logic rsp_empty;

    assign msp_full  = (msp_cnt == CNT_CAP);
    assign msp_empty = (msp_cnt == CNT_ZERO);
    assign rsp_full  = (rsp_cnt == CNT_CAP);
    assign rsp_empty = (rsp_cnt == CNT_ZERO);

    // Blocked pushes/pops leave the count alone, so the counters never wrap.
    always_ff @(posedge CLK or negedge RstN) begin
        if (!RstN) begin
            msp_cnt <= CNT_ZERO;
            msp_ovf <= 1'b0;
            msp_udf <= 1'b0;
        end else if (MSPRegReset) begin
            msp_cnt <= CNT_ZERO;
            msp_ovf <= 1'b0;
            msp_udf <= 1'b0;
        end else if (MSPWrite) begin
            if (!MSPop) begin
                if (msp_full) msp_ovf <= 1'b1;
                else          msp_cnt <= msp_cnt + CNT_ONE;
            end else begin
                if (msp_empty) msp_udf <= 1'b1;
                else           msp_cnt <= msp_cnt - CNT_ONE;
            end
        end
    end

    always_ff @(posedge CLK or negedge RstN) begin
        if (!RstN) begin
            rsp_cnt <= CNT_ZERO;
            rsp_ovf <= 1'b0;
            rsp_udf <= 1'b0;
        end else if (RSPRegReset) begin
            rsp_cnt <= CNT_ZERO;
            rsp_ovf <= 1'b0;
            rsp_udf <= 1'b0;
        end else if (RSPWrite) begin
            if (!RSPop) begin
                if (rsp_full) rsp_ovf <= 1'b1;
                else          rsp_cnt <= rsp_cnt + CNT_ONE;
            end else begin
                if (rsp_empty) rsp_udf <= 1'b1;
                else           rsp_cnt <= rsp_cnt - CNT_ONE;
            end
        end
    end

    // Top address of an empty stack is BASE-1 (mod 2^16); defined but never dereferenced.
    assign MSPPushAddr  = MSP_BASE + 16'(msp_cnt);
    assign MSPTopAddr   = MSPPushAddr - 16'd1;
    assign MSPCount     = msp_cnt;
    assign MSPEmpty     = msp_empty;
    assign MSPFull      = msp_full;
    assign MSPOverflow  = msp_ovf;
    assign MSPUnderflow = msp_udf;

    assign RSPPushAddr  = RSP_BASE + 16'(rsp_cnt);
    assign RSPTopAddr   = RSPPushAddr - 16'd1;
    assign RSPCount     = rsp_cnt;
    assign RSPEmpty     = rsp_empty;
    assign RSPFull      = rsp_full;
    assign RSPOverflow  = rsp_ovf;
    assign RSPUnderflow = rsp_udf;

    assign StackFault = msp_ovf | msp_udf | rsp_ovf | rsp_udf;

endmodule

// File: tb/tb_stack_pointer_unit.sv
// Directed and randomized checks of stack_pointer_unit against a count/flag model of both stacks.
// The model is updated once per clocked command and compared against every output.
module tb_stack_pointer_unit;

    localparam int MSP_B = 16'h0E00;
    localparam int RSP_B = 16'h0F00;
    localparam int CAP   = 256;

    logic        CLK;
    logic        RstN;
    logic        MSPWrite, MSPop, MSPRegReset;
    logic        RSPWrite, RSPop, RSPRegReset;
    logic [15:0] MSPPushAddr, MSPTopAddr, RSPPushAddr, RSPTopAddr;
    logic [8:0]  MSPCount, RSPCount;
    logic        MSPEmpty, MSPFull, MSPOverflow, MSPUnderflow;
    logic        RSPEmpty, RSPFull, RSPOverflow, RSPUnderflow;
    logic        StackFault;

    int checks = 0;
    int errors = 0;

    // Model state: index 0 = main stack, 1 = return stack.
    int m_cnt[2];
    bit m_ovf[2];
    bit m_udf[2];

    stack_pointer_unit dut (
        .CLK(CLK), .RstN(RstN),
        .MSPWrite(MSPWrite), .MSPop(MSPop), .MSPRegReset(MSPRegReset),
        .RSPWrite(RSPWrite), .RSPop(RSPop), .RSPRegReset(RSPRegReset),
        .MSPPushAddr(MSPPushAddr), .MSPTopAddr(MSPTopAddr), .MSPCount(MSPCount),
        .MSPEmpty(MSPEmpty), .MSPFull(MSPFull),
        .MSPOverflow(MSPOverflow), .MSPUnderflow(MSPUnderflow),
        .RSPPushAddr(RSPPushAddr), .RSPTopAddr(RSPTopAddr), .RSPCount(RSPCount),
        .RSPEmpty(RSPEmpty), .RSPFull(RSPFull),
        .RSPOverflow(RSPOverflow), .RSPUnderflow(RSPUnderflow),
        .StackFault(StackFault)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_cnt[s] = 0;
            m_ovf[s] = 1'b0;
            m_udf[s] = 1'b0;
        end
    endtask

    task automatic model_cmd(input int s, input bit w, input bit p, input bit r);
        if (r) begin
            m_cnt[s] = 0;
            m_ovf[s] = 1'b0;
            m_udf[s] = 1'b0;
        end else if (w && !p) begin
            if (m_cnt[s] == CAP) m_ovf[s] = 1'b1;
            else                 m_cnt[s] = m_cnt[s] + 1;
        end else if (w && p) begin
            if (m_cnt[s] == 0) m_udf[s] = 1'b1;
            else               m_cnt[s] = m_cnt[s] - 1;
        end
    endtask

    task automatic check_all();
        chk("msp_count", 32'(MSPCount), 32'(m_cnt[0]));
        chk("msp_push",  32'(MSPPushAddr), 32'((MSP_B + m_cnt[0]) & 16'hFFFF));
        chk("msp_top",   32'(MSPTopAddr), 32'((MSP_B + m_cnt[0] - 1) & 16'hFFFF));
        chk("msp_empty", 32'(MSPEmpty), 32'(m_cnt[0] == 0));
        chk("msp_full",  32'(MSPFull), 32'(m_cnt[0] == CAP));
        chk("msp_ovf",   32'(MSPOverflow), 32'(m_ovf[0]));
        chk("msp_udf",   32'(MSPUnderflow), 32'(m_udf[0]));
        chk("rsp_count", 32'(RSPCount), 32'(m_cnt[1]));
        chk("rsp_push",  32'(RSPPushAddr), 32'((RSP_B + m_cnt[1]) & 16'hFFFF));
        chk("rsp_top",   32'(RSPTopAddr), 32'((RSP_B + m_cnt[1] - 1) & 16'hFFFF));
        chk("rsp_empty", 32'(RSPEmpty), 32'(m_cnt[1] == 0));
        chk("rsp_full",  32'(RSPFull), 32'(m_cnt[1] == CAP));
        chk("rsp_ovf",   32'(RSPOverflow), 32'(m_ovf[1]));
        chk("rsp_udf",   32'(RSPUnderflow), 32'(m_udf[1]));
        chk("stack_fault", 32'(StackFault),
            32'(m_ovf[0] | m_udf[0] | m_ovf[1] | m_udf[1]));
    endtask

    // Drive one command cycle, step the model at the edge, then compare.
    task automatic step(input bit mw, input bit mp, input bit mr,
                        input bit rw, input bit rp, input bit rr);
        MSPWrite = mw; MSPop = mp; MSPRegReset = mr;
        RSPWrite = rw; RSPop = rp; RSPRegReset = rr;
        @(posedge CLK);
        model_cmd(0, mw, mp, mr);
        model_cmd(1, rw, rp, rr);
        #1;
        MSPWrite = 1'b0; MSPop = 1'b0; MSPRegReset = 1'b0;
        RSPWrite = 1'b0; RSPop = 1'b0; RSPRegReset = 1'b0;
        check_all();
    endtask

    initial begin
        RstN = 1'b0;
        MSPWrite = 1'b0; MSPop = 1'b0; MSPRegReset = 1'b0;
        RSPWrite = 1'b0; RSPop = 1'b0; RSPRegReset = 1'b0;
        model_reset();
        #22;
        check_all();
        chk("rst_msp_push", 32'(MSPPushAddr), 32'h0E00);
        chk("rst_msp_top",  32'(MSPTopAddr), 32'h0DFF);
        chk("rst_rsp_push", 32'(RSPPushAddr), 32'h0F00);
        #1 RstN = 1'b1;

        // Idle cycle after release: nothing changes.
        step(0, 0, 0, 0, 0, 0);

        // Three MSP pushes then a pop.
        step(1, 0, 0, 0, 0, 0);
        chk("msp_cnt_1", 32'(MSPCount), 32'd1);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("msp_cnt_3", 32'(MSPCount), 32'd3);
        step(1, 1, 0, 0, 0, 0);
        chk("msp_push_2", 32'(MSPPushAddr), 32'h0E02);
        chk("msp_top_2",  32'(MSPTopAddr), 32'h0E01);
        chk("rsp_untouched", 32'(RSPCount), 32'd0);

        // Pop ignored without Write.
        step(0, 1, 0, 0, 1, 0);

        // RSP underflow, sticky across a push, cleared by RegReset.
        step(0, 0, 0, 1, 1, 0);
        chk("rsp_udf_set", 32'(RSPUnderflow), 32'd1);
        chk("fault_set",   32'(StackFault), 32'd1);
        step(0, 0, 0, 1, 0, 0);
        chk("rsp_udf_sticky", 32'(RSPUnderflow), 32'd1);
        step(0, 0, 0, 0, 0, 1);
        chk("rsp_udf_clr", 32'(RSPUnderflow), 32'd0);

        // Fill the main stack, overflow, then pop.
        step(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < CAP; i++) step(1, 0, 0, 0, 0, 0);
        chk("msp_full_flag", 32'(MSPFull), 32'd1);
        chk("msp_push_full", 32'(MSPPushAddr), 32'h0F00);
        step(1, 0, 0, 0, 0, 0);
        chk("msp_cnt_sat", 32'(MSPCount), 32'd256);
        chk("msp_ovf_set", 32'(MSPOverflow), 32'd1);
        step(1, 1, 0, 0, 0, 0);
        chk("msp_cnt_255", 32'(MSPCount), 32'd255);
        chk("msp_ovf_sticky", 32'(MSPOverflow), 32'd1);

        // Same cycle: RegReset beats push on MSP while RSP pops.
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0);
        step(1, 0, 1, 1, 1, 0);
        chk("same_msp_cnt", 32'(MSPCount), 32'd0);
        chk("same_rsp_cnt", 32'(RSPCount), 32'd3);

        // Build non-empty stacks with a fault, then pulse reset between edges.
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 0, 0);
        chk("pre_async_fault", 32'(StackFault), 32'd1);
        #2 RstN = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("async_fault_clr", 32'(StackFault), 32'd0);
        chk("async_msp_push",  32'(MSPPushAddr), 32'h0E00);
        #2 RstN = 1'b1;

        // Randomized commands against the model.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 40) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 40) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
